f_le_iterative_responder: RTL and testbench
===========================================

# f_le_iterative_responder

Multi-cycle floating-point less-or-equal engine that serves comparison requests from sorting and min/max FSMs in the floating-point homework datapath. It takes one `{a, b}` request at a time on a valid/ready handshake. It classifies the operands, then compares the magnitudes chunk by chunk, MSB first. It returns a one-cycle `res_valid` pulse with `res = (a <= b)` and `err` for NaN operands.

## Interface
- `FLEN`, default 64: operand width (IEEE-754 binary64 layout: sign bit `FLEN-1`, 11-bit exponent, 52-bit fraction).
- `CHUNK`, default 16: magnitude bits compared per cycle. Must divide into `N = ceil((FLEN-1)/CHUNK)` chunks; the top chunk is zero-padded.
- `clk` input, 1 bit: clock; all state changes on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `req_valid` input, 1 bit: request present.
- `req_ready` output, 1 bit: high only in IDLE.
- `a`, `b` input, `FLEN` bits: operands, sampled when `req_valid & req_ready`.
- `res_valid` output, 1 bit: one-cycle result strobe.
- `res` output, 1 bit: `a <= b`.
- `err` output, 1 bit: either operand is NaN.

## Operation
- **Operand registers.** Operands are captured into internal registers on accept; the inputs are not looked at again until the next accept.
- **States.**
  - IDLE → CLASSIFY on accept.
  - CLASSIFY → DONE if the result is already decided; otherwise → COMPARE with chunk index `k = 1` (top chunk).
  - COMPARE → DONE after chunk `N`, or earlier when early exit applies (see Configuration).
  - DONE → IDLE unconditionally.
- **CLASSIFY decisions, in priority order:**
  - NaN: exponent all ones and fraction nonzero, on either operand → `err=1`, `res=0`.
  - Both zero, any signs → `res=1`.
  - Signs differ → `res = sign(a)`.
- **Both positive:** `res = mag(a) <= mag(b)`. Both negative: `res = mag(a) >= mag(b)`. `mag` is bits `FLEN-2:0`, compared as unsigned.
- **Chunk comparison.**
  - Each COMPARE cycle compares one chunk and latches the first unequal chunk's ordering in a sticky flag.
  - Lower chunks cannot override a decided flag.
  - All chunks equal → magnitudes equal → `res=1`.
- Infinities are treated as ordinary magnitudes: +inf ≥ any finite value, −inf ≤ any finite value.
- **Outputs.**
  - `res` and `err` are registered, update only when entering DONE, and hold until the next result.
  - `res_valid` is high exactly in DONE. There is no output backpressure; the consumer must take the result that cycle.
- **Request handling.**
  - `req_valid` while not in IDLE is ignored; nothing is queued.
  - `req_valid` may drop at any time without effect.

## Timing
- Latency is counted from the accept edge to `res_valid` high.
  - Decided in CLASSIFY (NaN, zeros, sign mismatch): 2 cycles.
  - Full magnitude compare: `2 + N` cycles, i.e. 6 at the defaults.
- Throughput is one request per (latency + 1) cycles; `req_ready` returns high the cycle after DONE.
- Reset values: `req_ready=1`, `res_valid=0`, `res=0`, `err=0`, state IDLE, chunk index 0.
- Reset mid-operation aborts the comparison: no `res_valid` is produced and the next cycle is IDLE with `req_ready=1`.
- Reset and `req_valid` in the same cycle: reset wins and no accept occurs.

## Configuration
- `F_LE_EARLY_EXIT_EN` defined: COMPARE goes to DONE on the first unequal chunk `k`, giving latency `2 + k`.
- `F_LE_EARLY_EXIT_EN` undefined: always `N` COMPARE cycles, giving a fixed latency of `2 + N` for non-decided operands.
- Results are identical in both builds; only latency differs.

## Test plan
- **Early exit, top chunk:** `a=0x3FF0000000000000` (1.0), `b=0x4000000000000000` (2.0) → `res=1`, `err=0`. Latency is 3 with the macro, 6 without.
- **LSB only:** `a=0x3FF0000000000001`, `b=0x3FF0000000000000` → `res=0` at latency 6 in both builds. Swapping the operands gives `res=1`.
- **Sign and zero cases:**
  - `a=0xBFF0000000000000` (−1.0), `b=0x3FF0000000000000` → `res=1` at latency 2.
  - `a=0x8000000000000000` (−0), `b=0x0000000000000000` → `res=1` at latency 2.
- **Negatives and NaN:**
  - `a=0xC000000000000000` (−2.0), `b=0xBFF0000000000000` → `res=1`.
  - `a=0x7FF8000000000000` (NaN), `b=0x0` → `err=1`, `res=0` at latency 2.
- **Busy and back-to-back:**
  - Hold `req_valid=1` with new operands during a compare → ignored, and `req_ready=0` until after DONE.
  - The second request is accepted on the cycle after DONE and `res_valid` pulses once per request.
- **Reset mid-operation:** assert `rst` during COMPARE of 1.0 vs 2.0 → no `res_valid`. Next cycle `req_ready=1`, `res=0`, `err=0`, and a fresh request completes normally.

Source files
------------

// File: rtl/f_le_iterative_responder.sv
// rtl/f_le_iterative_responder.sv - multi-cycle floating-point less-or-equal engine
//
// Purpose: accepts one {a, b} request at a time. It classifies the operands
// (NaN, both zero, sign mismatch) and then compares the magnitudes CHUNK bits
// per cycle, MSB first. It produces a one-cycle res_valid strobe with
// res = (a <= b) and err set for NaN operands.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   a, b                FLEN-bit binary64-layout operands, captured on accept
//   res_valid           high for exactly the DONE cycle
//   res, err            registered result, held until the next result
//
// Configuration macro: F_LE_EARLY_EXIT_EN. When it is defined, COMPARE ends on
// the first unequal chunk. When it is undefined, COMPARE always runs N cycles.

module f_le_iterative_responder #(
  parameter int FLEN  = 64,
  parameter int CHUNK = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  output logic            res_valid,
  output logic            res,
  output logic            err
);

  localparam int N  = (FLEN - 1 + CHUNK - 1) / CHUNK;
  localparam int MW = N * CHUNK;
  localparam int KW = $clog2(N + 1);
  localparam int EW = 11;
  localparam int FW = FLEN - 1 - EW;

`ifdef F_LE_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CLASSIFY, S_COMPARE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [FLEN-1:0] a_q, a_d, b_q, b_d;
  logic [KW-1:0]   k_q, k_d;
  logic            dec_q, dec_d;   // an unequal chunk has been seen
  logic            lt_q, lt_d;     // mag(a) < mag(b) at that first unequal chunk
  logic            res_q, res_d;
  logic            err_q, err_d;

  logic [MW-1:0]    mag_a, mag_b;
  logic [KW-1:0]    sel;
  logic [CHUNK-1:0] ca, cb;
  logic             chunk_ne, dec_now, lt_now, final_res;
  logic             nan_a, nan_b, zero_both, sign_diff;

  // Magnitudes are zero-padded at the top to a whole number of chunks.
  assign mag_a = MW'(a_q[FLEN-2:0]);
  assign mag_b = MW'(b_q[FLEN-2:0]);

  // Chunk k = 1 is the most significant chunk, which is slice N-1.
  assign sel = (k_q == '0) ? '0 : KW'(N) - k_q;
  assign ca  = mag_a[sel*CHUNK +: CHUNK];
  assign cb  = mag_b[sel*CHUNK +: CHUNK];

  assign nan_a     = (&a_q[FLEN-2 -: EW]) & (|a_q[FW-1:0]);
  assign nan_b     = (&b_q[FLEN-2 -: EW]) & (|b_q[FW-1:0]);
  assign zero_both = ~(|a_q[FLEN-2:0]) & ~(|b_q[FLEN-2:0]);
  assign sign_diff = a_q[FLEN-1] ^ b_q[FLEN-1];

  // Once the sticky flag is set, lower chunks cannot change the ordering.
  assign chunk_ne  = (ca != cb);
  assign dec_now   = dec_q | chunk_ne;
  assign lt_now    = dec_q ? lt_q : (ca < cb);
  // Equal magnitudes give a <= b. For negative operands the ordering is inverted.
  assign final_res = !dec_now ? 1'b1 : (a_q[FLEN-1] ? ~lt_now : lt_now);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    dec_d   = dec_q;
    lt_d    = lt_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d     = a;
          b_d     = b;
          k_d     = '0;
          dec_d   = 1'b0;
          lt_d    = 1'b0;
          state_d = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        if (nan_a | nan_b) begin
          err_d   = 1'b1;
          res_d   = 1'b0;
          state_d = S_DONE;
        end else if (zero_both) begin
          err_d   = 1'b0;
          res_d   = 1'b1;
          state_d = S_DONE;
        end else if (sign_diff) begin
          err_d   = 1'b0;
          res_d   = a_q[FLEN-1];
          state_d = S_DONE;
        end else begin
          k_d     = KW'(1);
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        dec_d = dec_now;
        lt_d  = lt_now;
        if ((k_q == KW'(N)) || (EARLY_EXIT && chunk_ne)) begin
          err_d   = 1'b0;
          res_d   = final_res;
          state_d = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DONE: begin
        k_d     = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      dec_q   <= 1'b0;
      lt_q    <= 1'b0;
      res_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      dec_q   <= dec_d;
      lt_q    <= lt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign res       = res_q;
  assign err       = err_q;

endmodule

// File: tb/tb_f_le_iterative_responder.sv
// tb/tb_f_le_iterative_responder.sv - directed self-checking bench for f_le_iterative_responder

module tb_f_le_iterative_responder;

  localparam logic [63:0] P_ONE  = 64'h3FF0000000000000;
  localparam logic [63:0] P_TWO  = 64'h4000000000000000;
  localparam logic [63:0] N_ONE  = 64'hBFF0000000000000;
  localparam logic [63:0] N_TWO  = 64'hC000000000000000;
  localparam logic [63:0] N_ZERO = 64'h8000000000000000;
  localparam logic [63:0] P_ZERO = 64'h0000000000000000;
  localparam logic [63:0] Q_NAN  = 64'h7FF8000000000000;
  localparam logic [63:0] P_INF  = 64'h7FF0000000000000;
  localparam logic [63:0] ONE_L  = 64'h3FF0000000000001;

  localparam int LAT_DEC  = 2;
  localparam int LAT_FULL = 6;
`ifdef F_LE_EARLY_EXIT_EN
  localparam int LAT_TOP = 3;
`else
  localparam int LAT_TOP = 6;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] a, b;
  logic        res_valid, res, err;

  int asserts  = 0;
  int failures = 0;
  int pulses   = 0;

  f_le_iterative_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a         (a),
    .b         (b),
    .res_valid (res_valid),
    .res       (res),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (res_valid === 1'b1) pulses++;

  // Called #1 after a rising edge while IDLE. Latency counts the CLASSIFY
  // cycle as 1. A value of -1 means res_valid never arrived.
  task automatic run_req(input logic [63:0] ta, input logic [63:0] tb_v,
                         output int lat, output logic r, output logic e);
    int cyc;
    lat = -1; r = 1'bx; e = 1'bx;
    a = ta; b = tb_v; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (res_valid === 1'b1) begin
        lat = cyc; r = res; e = err;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int p0;
    asserts++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    asserts++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", res_valid); end
    asserts++; if (res !== 1'b0) begin failures++; $display("FAIL reset_res got %b exp 0", res); end
    asserts++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b exp 0", err); end
    // When reset and req_valid are high together, reset wins.
    p0 = pulses;
    a = P_ONE; b = P_TWO; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b0;
    asserts++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_vs_valid_ready got %b exp 1", req_ready); end
    repeat (8) @(posedge clk); #1;
    asserts++; if (pulses != p0) begin failures++; $display("FAIL rst_vs_valid_pulses got %0d exp %0d", pulses, p0); end
  endtask

  task automatic test_early_exit();
    int lat; logic r, e;
    run_req(P_ONE, P_TWO, lat, r, e);
    asserts++; if (r !== 1'b1) begin failures++; $display("FAIL top_res got %b exp 1", r); end
    asserts++; if (e !== 1'b0) begin failures++; $display("FAIL top_err got %b exp 0", e); end
    asserts++; if (lat != LAT_TOP) begin failures++; $display("FAIL top_lat got %0d exp %0d", lat, LAT_TOP); end
    run_req(P_INF, P_ONE, lat, r, e);
    asserts++; if (r !== 1'b0) begin failures++; $display("FAIL inf_res got %b exp 0", r); end
  endtask

  task automatic test_lsb();
    int lat; logic r, e;
    run_req(ONE_L, P_ONE, lat, r, e);
    asserts++; if (r !== 1'b0) begin failures++; $display("FAIL lsb_res got %b exp 0", r); end
    asserts++; if (lat != LAT_FULL) begin failures++; $display("FAIL lsb_lat got %0d exp %0d", lat, LAT_FULL); end
    run_req(P_ONE, ONE_L, lat, r, e);
    asserts++; if (r !== 1'b1) begin failures++; $display("FAIL lsb_swap_res got %b exp 1", r); end
    asserts++; if (lat != LAT_FULL) begin failures++; $display("FAIL lsb_swap_lat got %0d exp %0d", lat, LAT_FULL); end
    run_req(P_ONE, P_ONE, lat, r, e);
    asserts++; if (r !== 1'b1) begin failures++; $display("FAIL equal_res got %b exp 1", r); end
    asserts++; if (lat != LAT_FULL) begin failures++; $display("FAIL equal_lat got %0d exp %0d", lat, LAT_FULL); end
  endtask

  task automatic test_sign_zero();
    int lat; logic r, e;
    run_req(N_ONE, P_ONE, lat, r, e);
    asserts++; if (r !== 1'b1) begin failures++; $display("FAIL sign_res got %b exp 1", r); end
    asserts++; if (lat != LAT_DEC) begin failures++; $display("FAIL sign_lat got %0d exp %0d", lat, LAT_DEC); end
    run_req(P_ONE, N_ONE, lat, r, e);
    asserts++; if (r !== 1'b0) begin failures++; $display("FAIL sign_swap_res got %b exp 0", r); end
    run_req(N_ZERO, P_ZERO, lat, r, e);
    asserts++; if (r !== 1'b1) begin failures++; $display("FAIL zero_res got %b exp 1", r); end
    asserts++; if (lat != LAT_DEC) begin failures++; $display("FAIL zero_lat got %0d exp %0d", lat, LAT_DEC); end
    run_req(P_ZERO, N_ZERO, lat, r, e);
    asserts++; if (r !== 1'b1) begin failures++; $display("FAIL zero_swap_res got %b exp 1", r); end
  endtask

  task automatic test_neg_nan();
    int lat; logic r, e;
    run_req(N_TWO, N_ONE, lat, r, e);
    asserts++; if (r !== 1'b1) begin failures++; $display("FAIL neg_res got %b exp 1", r); end
    asserts++; if (lat != LAT_TOP) begin failures++; $display("FAIL neg_lat got %0d exp %0d", lat, LAT_TOP); end
    run_req(N_ONE, N_TWO, lat, r, e);
    asserts++; if (r !== 1'b0) begin failures++; $display("FAIL neg_swap_res got %b exp 0", r); end
    run_req(Q_NAN, P_ZERO, lat, r, e);
    asserts++; if (e !== 1'b1) begin failures++; $display("FAIL nan_err got %b exp 1", e); end
    asserts++; if (r !== 1'b0) begin failures++; $display("FAIL nan_res got %b exp 0", r); end
    asserts++; if (lat != LAT_DEC) begin failures++; $display("FAIL nan_lat got %0d exp %0d", lat, LAT_DEC); end
    run_req(P_ONE, P_TWO, lat, r, e);
    asserts++; if (e !== 1'b0) begin failures++; $display("FAIL nan_clear_err got %b exp 0", e); end
  endtask

  task automatic test_back_to_back();
    int lat, p0, busy_ready;
    logic r1;
    p0 = pulses; busy_ready = 0; lat = -1; r1 = 1'bx;
    a = P_ONE; b = P_TWO; req_valid = 1'b1;
    @(posedge clk); #1;
    // The new operands stay presented during the busy period and must be ignored.
    a = P_TWO; b = P_ONE;
    for (int i = 2; i < 22; i++) begin
      @(posedge clk); #1;
      if (res_valid === 1'b1) begin lat = i; r1 = res; break; end
      if (req_ready !== 1'b0) busy_ready++;
    end
    asserts++; if (lat != LAT_TOP) begin failures++; $display("FAIL b2b_first_lat got %0d exp %0d", lat, LAT_TOP); end
    asserts++; if (r1 !== 1'b1) begin failures++; $display("FAIL b2b_first_res got %b exp 1", r1); end
    asserts++; if (busy_ready != 0) begin failures++; $display("FAIL b2b_busy_ready got %0d cycles exp 0", busy_ready); end
    asserts++; if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_done_ready got %b exp 0", req_ready); end
    @(posedge clk); #1;
    asserts++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle_ready got %b exp 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    asserts++; if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_accept got %b exp 0", req_ready); end
    lat = -1; r1 = 1'bx;
    for (int i = 2; i < 22; i++) begin
      @(posedge clk); #1;
      if (res_valid === 1'b1) begin lat = i; r1 = res; break; end
    end
    asserts++; if (r1 !== 1'b0) begin failures++; $display("FAIL b2b_second_res got %b exp 0", r1); end
    asserts++; if (lat != LAT_TOP) begin failures++; $display("FAIL b2b_second_lat got %0d exp %0d", lat, LAT_TOP); end
    repeat (3) @(posedge clk); #1;
    asserts++; if (pulses != p0 + 2) begin failures++; $display("FAIL b2b_pulses got %0d exp %0d", pulses - p0, 2); end
  endtask

  task automatic test_reset_mid();
    int lat, p0; logic r, e;
    run_req(N_ZERO, P_ZERO, lat, r, e);
    p0 = pulses;
    a = P_ONE; b = P_TWO; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    asserts++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got %b exp 1", req_ready); end
    asserts++; if (res !== 1'b0) begin failures++; $display("FAIL mid_rst_res got %b exp 0", res); end
    asserts++; if (err !== 1'b0) begin failures++; $display("FAIL mid_rst_err got %b exp 0", err); end
    repeat (8) @(posedge clk); #1;
    asserts++; if (pulses != p0) begin failures++; $display("FAIL mid_rst_pulses got %0d exp %0d", pulses, p0); end
    run_req(N_ONE, P_ONE, lat, r, e);
    asserts++; if (r !== 1'b1) begin failures++; $display("FAIL post_rst_res got %b exp 1", r); end
    asserts++; if (lat != LAT_DEC) begin failures++; $display("FAIL post_rst_lat got %0d exp %0d", lat, LAT_DEC); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk); #1;
    test_reset();
    test_early_exit();
    test_lsb();
    test_sign_zero();
    test_neg_nan();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
